// File: rtl/sc1_sel_seq_pkg.sv
// ----------------------------------------------------------------------------
// sc1_pkg : shared types and helpers for the sc1 select sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sc1_pkg;

  localparam int CH_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sc1_state_t;

  // Channel 0 is reserved; only 1..num_ch take part in arbitration.
  function automatic logic sc1_ch_valid(input int ch, input int num_ch);
    return (ch >= 1) && (ch <= num_ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc1_sel_seq_if.sv
// ----------------------------------------------------------------------------
// sc1_sel_seq_if : request/acknowledge and mux-select bundle of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sc1_sel_seq_if;
  import sc1_pkg::*;

  logic [15:0]     req;
  logic            grant_ack;
  logic [CH_W-1:0] encoder_in;
  logic            enable;
  logic            timeout;
  logic            busy;

  modport master (
    output req,
    output grant_ack,
    input  encoder_in,
    input  enable,
    input  timeout,
    input  busy
  );

  modport slave (
    input  req,
    input  grant_ack,
    output encoder_in,
    output enable,
    output timeout,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/sc1_sel_seq_rr_pick.sv
// ----------------------------------------------------------------------------
// sc1_rr_pick : combinational round-robin search starting after last_i
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sc1_rr_pick
  import sc1_pkg::*;
#(
  parameter int NUM_CH = 11
) (
  input  logic [15:0]     req_i,
  input  logic [CH_W-1:0] last_i,
  output logic            found_o,
  output logic [CH_W-1:0] pick_o
);

  // last_i+1 .. NUM_CH, then 1 .. last_i; last_i itself is visited last.
  always_comb begin
    int idx;
    found_o = 1'b0;
    pick_o  = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(last_i) + i;
      if (idx > NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!found_o && sc1_ch_valid(idx, NUM_CH) && req_i[idx[3:0]]) begin
        found_o = 1'b1;
        pick_o  = idx[CH_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sc1_sel_seq.sv
// ----------------------------------------------------------------------------
// sc1_sel_seq : round-robin grant sequencer driving the sc1 16:1 mux select
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sc1_sel_seq
  import sc1_pkg::*;
#(
  parameter int NUM_CH    = 11,
  parameter int MIN_DWELL = 2,
  parameter int TIMEOUT   = 64
) (
  input logic          clk,
  input logic          rst_n,
  sc1_sel_seq_if.slave bus
);

  localparam int                    c_DWELL_W  = $clog2(TIMEOUT + 1);
  localparam logic [c_DWELL_W-1:0] c_ACK_MIN  = c_DWELL_W'(MIN_DWELL - 1);
  localparam logic [c_DWELL_W-1:0] c_TO_LAST  = c_DWELL_W'(TIMEOUT - 1);
  localparam logic [c_DWELL_W-1:0] c_TO_SAT   = c_DWELL_W'(TIMEOUT);
  localparam logic [CH_W-1:0]      c_LAST_RST = CH_W'(NUM_CH);

  sc1_state_t           state_q, state_d;
  logic [CH_W-1:0]      enc_q, enc_d;
  logic                 en_q, en_d;
  logic                 to_q, to_d;
  logic [CH_W-1:0]      last_q, last_d;
  logic [c_DWELL_W-1:0] dwell_q, dwell_d;
  logic                 ackp_q, ackp_d;
  logic                 arm_q;

  logic [CH_W-1:0]      pick_last;
  logic                 found;
  logic [CH_W-1:0]      pick;
  logic                 ack_ok;
  logic                 abort;
  logic                 to_hit;

  // While granting, the search for the follow-on channel starts after the
  // channel being released, so a back-to-back switch needs no extra cycle.
  assign pick_last = (state_q == GRANT) ? enc_q : last_q;

  sc1_rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req_i   (bus.req),
    .last_i  (pick_last),
    .found_o (found),
    .pick_o  (pick)
  );

  assign ack_ok = (ackp_q | bus.grant_ack) && (dwell_q >= c_ACK_MIN);
  assign abort  = ~bus.req[enc_q];
  assign to_hit = (dwell_q == c_TO_LAST);

  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    en_d    = en_q;
    to_d    = 1'b0;
    last_d  = last_q;
    dwell_d = dwell_q;
    ackp_d  = ackp_q;
    case (state_q)
      IDLE: begin
        if (arm_q && found) begin
          enc_d   = pick;
          en_d    = 1'b1;
          dwell_d = '0;
          ackp_d  = 1'b0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack_ok || abort || to_hit) begin
          to_d    = ~ack_ok & ~abort;
          last_d  = enc_q;
          ackp_d  = 1'b0;
          dwell_d = '0;
          if (found) begin
            enc_d = pick;
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          if (dwell_q != c_TO_SAT) begin
            dwell_d = dwell_q + 1'b1;
          end
          if (bus.grant_ack) begin
            ackp_d = 1'b1;
          end
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // arm_q holds off the first edge after reset so that edge only settles state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      enc_q   <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
      last_q  <= c_LAST_RST;
      dwell_q <= '0;
      ackp_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      en_q    <= en_d;
      to_q    <= to_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      ackp_q  <= ackp_d;
      arm_q   <= 1'b1;
    end
  end

  assign bus.encoder_in = enc_q;
  assign bus.enable     = en_q;
  assign bus.busy       = en_q;
  assign bus.timeout    = to_q;

endmodule

`default_nettype wire

// File: tb/tb_sc1_sel_seq.sv
// ----------------------------------------------------------------------------
// tb_sc1_sel_seq : scenario tasks plus a cycle-level reference of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sc1_sel_seq;
  import sc1_pkg::*;

  localparam int NCH  = 11;
  localparam int MIND = 4;
  localparam int TOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc1_sel_seq_if bus ();

  sc1_sel_seq #(
    .NUM_CH    (NCH),
    .MIN_DWELL (MIND),
    .TIMEOUT   (TOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference: granted channel, cycles already spent on it, last channel served.
  int m_enc, m_last, m_held;
  bit m_en, m_to, m_ackp, m_armed;

  function automatic int m_pick(input int last, input logic [15:0] r);
    int ch;
    for (int k = 1; k <= NCH; k++) begin
      ch = (last + k - 1) % NCH + 1;
      if (r[ch]) return ch;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_enc = 0; m_en = 0; m_to = 0; m_last = NCH; m_held = 0; m_ackp = 0; m_armed = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  ackok, abrt, tmo;
    m_to = 0;
    if (!m_armed) begin
      m_armed = 1;
    end else if (!m_en) begin
      nxt = m_pick(m_last, bus.req);
      if (nxt != 0) begin
        m_enc = nxt; m_en = 1; m_held = 0; m_ackp = 0;
      end
    end else begin
      ackok = (m_ackp || bus.grant_ack) && (m_held + 1 >= MIND);
      abrt  = !bus.req[m_enc];
      tmo   = (m_held + 1 == TOUT);
      if (ackok || abrt || tmo) begin
        m_to   = !ackok && !abrt;
        m_last = m_enc;
        m_ackp = 0;
        nxt    = m_pick(m_last, bus.req);
        if (nxt != 0) begin
          m_enc = nxt; m_held = 0;
        end else begin
          m_en = 0;
        end
      end else begin
        m_held++;
        if (bus.grant_ack) m_ackp = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req = '0; bus.grant_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit saw2, gap;
    bus.req = 16'h0006; bus.grant_ack = 1'b0;
    rst_n = 1'b0; model_reset();
    @(negedge clk); @(negedge clk);
    total++;
    if (bus.encoder_in !== 4'd0 || bus.enable !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got enc=%0d en=%b to=%b busy=%b want all 0",
                      bus.encoder_in, bus.enable, bus.timeout, bus.busy);
    end
    rst_n = 1'b1;
    cycle();
    total++;
    if (bus.enable !== 1'b0) begin
      bad++; $display("FAIL first_edge_idle got en=%b want 0", bus.enable);
    end
    cycle();
    total++;
    if (bus.encoder_in !== 4'd1 || bus.enable !== 1'b1) begin
      bad++; $display("FAIL first_grant got enc=%0d en=%b want enc=1 en=1", bus.encoder_in, bus.enable);
    end
    bus.grant_ack = 1'b1; saw2 = 0; gap = 0;
    for (int i = 0; i < 20 && !(saw2 && !bus.enable); i++) begin
      cycle();
      total++;
      if ({bus.encoder_in, bus.enable, bus.timeout, bus.busy} !== {4'(m_enc), m_en, m_to, m_en}) begin
        bad++; $display("FAIL reset_seq got enc=%0d en=%b to=%b want enc=%0d en=%b to=%b",
                        bus.encoder_in, bus.enable, bus.timeout, m_enc, m_en, m_to);
      end
      if (!bus.enable && !saw2) gap = 1;
      if (bus.enable && bus.encoder_in == 4'd2) begin saw2 = 1; bus.req = 16'h0000; end
    end
    total++;
    if (!saw2 || gap || bus.enable !== 1'b0) begin
      bad++; $display("FAIL b2b_then_idle got saw2=%b gap=%b en=%b want 1 0 0", saw2, gap, bus.enable);
    end
    bus.grant_ack = 1'b0;
  endtask

  task automatic test_wrap();
    int order[$];
    bit prev_en;
    int prev_enc;
    do_reset();
    bus.req = 16'h0802; bus.grant_ack = 1'b1;
    prev_en = 0; prev_enc = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      total++;
      if ({bus.encoder_in, bus.enable, bus.timeout} !== {4'(m_enc), m_en, m_to}) begin
        bad++; $display("FAIL wrap_seq got enc=%0d en=%b to=%b want enc=%0d en=%b to=%b",
                        bus.encoder_in, bus.enable, bus.timeout, m_enc, m_en, m_to);
      end
      if (bus.enable && (!prev_en || int'(bus.encoder_in) != prev_enc)) order.push_back(int'(bus.encoder_in));
      prev_en = bus.enable; prev_enc = int'(bus.encoder_in);
    end
    total++;
    if (order.size() < 3 || order[0] != 1 || order[1] != 11 || order[2] != 1) begin
      bad++; $display("FAIL wrap_order got n=%0d first=%0d,%0d,%0d want 1,11,1", order.size(),
                      order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1,
                      order.size() > 2 ? order[2] : -1);
    end
    bus.grant_ack = 1'b0;
  endtask

  task automatic test_min_dwell();
    int n;
    do_reset();
    bus.req = 16'h000C;
    for (int i = 0; i < 6 && !bus.enable; i++) cycle();
    total++;
    if (bus.enable !== 1'b1 || bus.encoder_in !== 4'd2) begin
      bad++; $display("FAIL dwell_grant got en=%b enc=%0d want en=1 enc=2", bus.enable, bus.encoder_in);
    end
    n = 1;
    bus.grant_ack = 1'b1;
    cycle();
    bus.grant_ack = 1'b0;
    for (int i = 0; i < 12 && bus.enable && bus.encoder_in == 4'd2; i++) begin
      total++;
      if ({bus.encoder_in, bus.enable, bus.timeout} !== {4'(m_enc), m_en, m_to}) begin
        bad++; $display("FAIL dwell_seq got enc=%0d en=%b want enc=%0d en=%b",
                        bus.encoder_in, bus.enable, m_enc, m_en);
      end
      n++;
      cycle();
    end
    total++;
    if (n != MIND || bus.encoder_in !== 4'd3 || bus.enable !== 1'b1) begin
      bad++; $display("FAIL min_dwell got cycles=%0d enc=%0d en=%b want cycles=%0d enc=3 en=1",
                      n, bus.encoder_in, bus.enable, MIND);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.req = 16'h0010;
    for (int i = 0; i < 6 && !bus.enable; i++) cycle();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      total++;
      if ({bus.encoder_in, bus.enable, bus.timeout} !== {4'(m_enc), m_en, m_to}) begin
        bad++; $display("FAIL to_seq got enc=%0d en=%b to=%b want enc=%0d en=%b to=%b",
                        bus.encoder_in, bus.enable, bus.timeout, m_enc, m_en, m_to);
      end
      if (bus.timeout) break;
      n++;
    end
    total++;
    if (n != TOUT || bus.timeout !== 1'b1 || bus.encoder_in !== 4'd4 || bus.enable !== 1'b1) begin
      bad++; $display("FAIL timeout_regrant got cycles=%0d to=%b enc=%0d en=%b want cycles=%0d to=1 enc=4 en=1",
                      n, bus.timeout, bus.encoder_in, bus.enable, TOUT);
    end
    cycle();
    total++;
    if (bus.timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_one_cycle got to=%b want 0", bus.timeout);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.req = 16'h8001;
    for (int i = 0; i < 10; i++) begin
      cycle();
      total++;
      if (bus.enable !== 1'b0) begin
        bad++; $display("FAIL ignored_bits got en=%b enc=%0d want en=0", bus.enable, bus.encoder_in);
      end
    end
    bus.req = 16'h0008;
    cycle();
    total++;
    if (bus.enable !== 1'b1 || bus.encoder_in !== 4'd3) begin
      bad++; $display("FAIL abort_grant got en=%b enc=%0d want en=1 enc=3", bus.enable, bus.encoder_in);
    end
    bus.req = 16'h0000;
    cycle();
    total++;
    if (bus.enable !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++; $display("FAIL abort_release got en=%b to=%b want en=0 to=0", bus.enable, bus.timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 16'h0FFE;
    cycle(); cycle();
    bus.grant_ack = 1'b1;
    for (int i = 0; i < MIND; i++) cycle();
    total++;
    if (bus.enable !== 1'b1 || bus.encoder_in !== 4'd2) begin
      bad++; $display("FAIL pre_reset_grant got en=%b enc=%0d want en=1 enc=2", bus.enable, bus.encoder_in);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus.enable !== 1'b0 || bus.encoder_in !== 4'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL async_reset got en=%b enc=%0d busy=%b want 0 0 0",
                      bus.enable, bus.encoder_in, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.grant_ack = 1'b0;
    cycle(); cycle();
    total++;
    if (bus.enable !== 1'b1 || bus.encoder_in !== 4'd1) begin
      bad++; $display("FAIL post_reset_grant got en=%b enc=%0d want en=1 enc=1", bus.enable, bus.encoder_in);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.req = 16'h0000;
          1:       bus.req = 16'(1 << $urandom_range(0, 15));
          default: bus.req = 16'($urandom);
        endcase
        hold = $urandom_range(1, 14);
      end
      hold--;
      bus.grant_ack = ($urandom_range(0, 3) == 0);
      cycle();
      total++;
      if ({bus.encoder_in, bus.enable, bus.timeout, bus.busy} !== {4'(m_enc), m_en, m_to, m_en}) begin
        bad++; $display("FAIL random_cycle%0d got enc=%0d en=%b to=%b busy=%b want enc=%0d en=%b to=%b",
                        i, bus.encoder_in, bus.enable, bus.timeout, bus.busy, m_enc, m_en, m_to);
      end
    end
    bus.grant_ack = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.grant_ack = 1'b0;
    test_reset();
    test_wrap();
    test_min_dwell();
    test_timeout();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
